mem_port_arbiter: RTL and testbench

Shares the single-port main memory between the instruction-fetch path and the load/store path of the multicycle MIPS datapath. It replaces hard-coded memory wait states in the main control FSM with a request/done handshake. It sequences each access, counts the fixed memory read latency and returns captured read data to the winning requester. It sits between the control unit / datapath registers and the memory instance.

---
 rtl/mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port main memory: sequences instruction-fetch and
// load/store accesses, counts the fixed read latency and returns read data.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  output logic [DATA_W-1:0] IfRdata,
  output logic              IfDone,
  input  logic              LsReq,
  input  logic              LsWe,
  input  logic [ADDR_W-1:0] LsAddr,
  input  logic [DATA_W-1:0] LsWdata,
  output logic [DATA_W-1:0] LsRdata,
  output logic              LsDone,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_e;

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT - 1);

  state_e             state_q,     state_d;
  logic [2:0]         lat_cnt_q,   lat_cnt_d;
  logic               if_pend_q,   if_pend_d;
  logic               ls_pend_q,   ls_pend_d;
  logic [DATA_W-1:0]  if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]  ls_rdata_q,  ls_rdata_d;

  // Holding and active request fields; qualified by pending flags and state.
  logic [ADDR_W-1:0]  if_addr_q,   if_addr_d;
  logic [ADDR_W-1:0]  ls_addr_q,   ls_addr_d;
  logic               ls_we_q,     ls_we_d;
  logic [DATA_W-1:0]  ls_wdata_q,  ls_wdata_d;
  owner_e             act_owner_q, act_owner_d;
  logic               act_we_q,    act_we_d;
  logic [ADDR_W-1:0]  act_addr_q,  act_addr_d;
  logic [DATA_W-1:0]  act_wdata_q, act_wdata_d;

  logic               arb_en;
  logic               in_access;
  logic               if_accept,   ls_accept;
  logic               if_cand,     ls_cand;
  logic               if_grant,    ls_grant;
  logic [ADDR_W-1:0]  if_src_addr, ls_src_addr;
  logic               ls_src_we;
  logic [DATA_W-1:0]  ls_src_wdata;

  // Request acceptance and fixed-priority arbitration (LS over IF).
  always_comb begin
    arb_en    = (state_q == S_IDLE) || (state_q == S_DONE);
    in_access = (state_q == S_ACCESS) || (state_q == S_WAIT) ||
                (state_q == S_CAPTURE);

    if_accept = IfReq && !if_pend_q && !(in_access && act_owner_q == OWN_IF);
    ls_accept = LsReq && !ls_pend_q && !(in_access && act_owner_q == OWN_LS);

    if_cand   = if_pend_q || if_accept;
    ls_cand   = ls_pend_q || ls_accept;
    ls_grant  = arb_en && ls_cand;
    if_grant  = arb_en && if_cand && !ls_cand;

    if_src_addr  = if_pend_q ? if_addr_q  : IfAddr;
    ls_src_addr  = ls_pend_q ? ls_addr_q  : LsAddr;
    ls_src_we    = ls_pend_q ? ls_we_q    : LsWe;
    ls_src_wdata = ls_pend_q ? ls_wdata_q : LsWdata;
  end

  // Next-state logic for the FSM, holding registers and read-data registers.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    if_pend_d   = if_pend_q;
    ls_pend_d   = ls_pend_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_addr_d   = if_addr_q;
    ls_addr_d   = ls_addr_q;
    ls_we_d     = ls_we_q;
    ls_wdata_d  = ls_wdata_q;
    act_owner_d = act_owner_q;
    act_we_d    = act_we_q;
    act_addr_d  = act_addr_q;
    act_wdata_d = act_wdata_q;

    if (if_accept) begin
      if_pend_d = 1'b1;
      if_addr_d = IfAddr;
    end
    if (ls_accept) begin
      ls_pend_d  = 1'b1;
      ls_addr_d  = LsAddr;
      ls_we_d    = LsWe;
      ls_wdata_d = LsWdata;
    end

    if (ls_grant) begin
      ls_pend_d   = 1'b0;
      act_owner_d = OWN_LS;
      act_we_d    = ls_src_we;
      act_addr_d  = ls_src_addr;
      act_wdata_d = ls_src_wdata;
    end else if (if_grant) begin
      if_pend_d   = 1'b0;
      act_owner_d = OWN_IF;
      act_we_d    = 1'b0;
      act_addr_d  = if_src_addr;
      act_wdata_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (ls_grant || if_grant) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (act_we_q) begin
          state_d = S_DONE;
        end else begin
          lat_cnt_d = LAT_INIT;
          state_d   = (READ_LAT == 1) ? S_CAPTURE : S_WAIT;
        end
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q == 3'd1) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (act_owner_q == OWN_IF) if_rdata_d = MemRdata;
        else                       ls_rdata_d = MemRdata;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = (ls_grant || if_grant) ? S_ACCESS : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory-side and requester-side outputs decoded from the current state.
  always_comb begin
    MemAddr  = '0;
    MemWdata = '0;
    MemWrite = 1'b0;
    IfDone   = 1'b0;
    LsDone   = 1'b0;
    case (state_q)
      S_ACCESS: begin
        MemAddr = act_addr_q;
        if (act_we_q) begin
          MemWrite = 1'b1;
          MemWdata = act_wdata_q;
        end
      end
      S_WAIT, S_CAPTURE: MemAddr = act_addr_q;
      S_DONE: begin
        IfDone = (act_owner_q == OWN_IF);
        LsDone = (act_owner_q == OWN_LS);
      end
      default: ;
    endcase
  end

  assign IfRdata = if_rdata_q;
  assign LsRdata = ls_rdata_q;
  assign Busy    = (state_q != S_IDLE) || if_pend_q || ls_pend_q;

  // Control state and returned read data: reset to the documented values.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value regardless of statement order.
    if (Reset) begin
      state_q    <= S_IDLE;
      lat_cnt_q  <= 3'd0;
      if_pend_q  <= 1'b0;
      ls_pend_q  <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      if_pend_q  <= if_pend_d;
      ls_pend_q  <= ls_pend_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // NOTE: request payload registers carry no reset; they are only read while
  // a pending flag or the FSM state says they hold a live request.
  always_ff @(posedge Clk) begin
    if_addr_q   <= if_addr_d;
    ls_addr_q   <= ls_addr_d;
    ls_we_q     <= ls_we_d;
    ls_wdata_q  <= ls_wdata_d;
    act_owner_q <= act_owner_d;
    act_we_q    <= act_we_d;
    act_addr_q  <= act_addr_d;
    act_wdata_q <= act_wdata_d;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three builds (READ_LAT 2, 1, 7) share
// stimulus; expected values are hand-derived cycle by cycle.
module tb_mem_port_arbiter;

  localparam int LATS [3] = '{2, 1, 7};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [31:0] mem_rdata = '0;

  logic [2:0][31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [2:0]       if_done, ls_done, mem_write, busy;

  int n_pass  = 0;
  int n_total = 0;
  int n_ifdone;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .READ_LAT(LATS[g])
    ) u_dut (
      .Clk     (clk),
      .Reset   (reset),
      .IfReq   (if_req),
      .IfAddr  (if_addr),
      .IfRdata (if_rdata[g]),
      .IfDone  (if_done[g]),
      .LsReq   (ls_req),
      .LsWe    (ls_we),
      .LsAddr  (ls_addr),
      .LsWdata (ls_wdata),
      .LsRdata (ls_rdata[g]),
      .LsDone  (ls_done[g]),
      .MemAddr (mem_addr[g]),
      .MemWdata(mem_wdata[g]),
      .MemWrite(mem_write[g]),
      .MemRdata(mem_rdata),
      .Busy    (busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; requests are single-cycle pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if_req = 1'b0;
    ls_req = 1'b0;
  endtask

  initial begin
    // ---- reset with stimulus active ----
    repeat (2) tick();
    reset = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEADBEEF;
    tick();
    check("pre_rst mem_write", mem_write[0], 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst mem_write", mem_write[0], 1'b0);
    check("rst mem_addr", mem_addr[0], 32'h0);
    check("rst mem_wdata", mem_wdata[0], 32'h0);
    check("rst busy", busy[0], 1'b0);
    check("rst dones", {if_done[0], ls_done[0]}, 2'b00);
    check("rst if_rdata", if_rdata[0], 32'h0);
    check("rst ls_rdata", ls_rdata[0], 32'h0);
    check("rst busy lat7", busy[2], 1'b0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("idle c%0d busy", c), busy[0], 1'b0);
      check($sformatf("idle c%0d mem_write", c), mem_write[0], 1'b0);
      tick();
    end

    // ---- IF read, READ_LAT = 2 ----
    if_req = 1'b1; if_addr = 32'h40; ls_we = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      mem_rdata = (c == 3) ? 32'h8C220004 : 32'hBAD00000 + 32'(c);
      check($sformatf("ifrd c%0d mem_addr", c), mem_addr[0], (c <= 3) ? 32'h40 : 32'h0);
      check($sformatf("ifrd c%0d if_done", c), if_done[0], c == 4);
      check($sformatf("ifrd c%0d ls_done", c), ls_done[0], 1'b0);
      check($sformatf("ifrd c%0d busy", c), busy[0], c <= 4);
      if (c >= 4) check($sformatf("ifrd c%0d if_rdata", c), if_rdata[0], 32'h8C220004);
    end

    // ---- LS load, READ_LAT = 2 ----
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80;
    for (int c = 1; c <= 5; c++) begin
      tick();
      mem_rdata = 32'h11110000 + 32'(c);
      check($sformatf("ldrd c%0d mem_addr", c), mem_addr[0], (c <= 3) ? 32'h80 : 32'h0);
      check($sformatf("ldrd c%0d ls_done", c), ls_done[0], c == 4);
      check($sformatf("ldrd c%0d if_done", c), if_done[0], 1'b0);
      if (c >= 4) check($sformatf("ldrd c%0d ls_rdata", c), ls_rdata[0], 32'h11110003);
    end

    // ---- store ----
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      mem_rdata = 32'h55550000 + 32'(c);
      check($sformatf("st c%0d mem_write", c), mem_write[0], c == 1);
      check($sformatf("st c%0d mem_addr", c), mem_addr[0], (c == 1) ? 32'h100 : 32'h0);
      check($sformatf("st c%0d mem_wdata", c), mem_wdata[0], (c == 1) ? 32'hDEADBEEF : 32'h0);
      check($sformatf("st c%0d ls_done", c), ls_done[0], c == 2);
      check($sformatf("st c%0d busy", c), busy[0], c <= 2);
      check($sformatf("st c%0d ls_rdata", c), ls_rdata[0], 32'h11110003);
    end

    // ---- collision: LS load wins, IF pending; extra IfReqs ignored ----
    if_req = 1'b1; if_addr = 32'h44;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
    n_ifdone = 0;
    for (int c = 1; c <= 12; c++) begin
      logic [31:0] exp_addr;
      tick();
      mem_rdata = 32'hC0000000 + 32'(c);
      if (c == 3) begin if_req = 1'b1; if_addr = 32'h99; end
      if (c == 6) begin if_req = 1'b1; if_addr = 32'h88; end
      if (if_done[0]) n_ifdone++;
      exp_addr = (c <= 3) ? 32'h200 : (c >= 5 && c <= 7) ? 32'h44 : 32'h0;
      check($sformatf("col c%0d mem_addr", c), mem_addr[0], exp_addr);
      check($sformatf("col c%0d ls_done", c), ls_done[0], c == 4);
      check($sformatf("col c%0d if_done", c), if_done[0], c == 8);
      check($sformatf("col c%0d busy", c), busy[0], c <= 8);
      if (c >= 4) check($sformatf("col c%0d ls_rdata", c), ls_rdata[0], 32'hC0000003);
      if (c >= 8) check($sformatf("col c%0d if_rdata", c), if_rdata[0], 32'hC0000007);
    end
    check("col if_done count", 32'(n_ifdone), 32'd1);

    // ---- reset in the middle of an IF read ----
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("midrst if_done", if_done[0], 1'b0);
    check("midrst if_rdata", if_rdata[0], 32'h0);
    check("midrst ls_rdata", ls_rdata[0], 32'h0);
    check("midrst busy", busy[0], 1'b0);
    check("midrst mem_addr", mem_addr[0], 32'h0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("midrst post c%0d if_done", c), if_done[0], 1'b0);
      check($sformatf("midrst post c%0d busy", c), busy[0], 1'b0);
      tick();
    end
    if_req = 1'b1; if_addr = 32'h48;
    for (int c = 1; c <= 5; c++) begin
      tick();
      mem_rdata = 32'hE0000000 + 32'(c);
      check($sformatf("rerd c%0d mem_addr", c), mem_addr[0], (c <= 3) ? 32'h48 : 32'h0);
      check($sformatf("rerd c%0d if_done", c), if_done[0], c == 4);
      if (c >= 4) check($sformatf("rerd c%0d if_rdata", c), if_rdata[0], 32'hE0000003);
    end

    // ---- LS load on the READ_LAT = 1 and 7 builds ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300;
    for (int c = 1; c <= 11; c++) begin
      tick();
      mem_rdata = 32'hA0000000 + 32'(c);
      check($sformatf("lat1 c%0d mem_addr", c), mem_addr[1], (c <= 2) ? 32'h300 : 32'h0);
      check($sformatf("lat1 c%0d ls_done", c), ls_done[1], c == 3);
      if (c >= 3) check($sformatf("lat1 c%0d ls_rdata", c), ls_rdata[1], 32'hA0000002);
      check($sformatf("lat7 c%0d mem_addr", c), mem_addr[2], (c <= 8) ? 32'h300 : 32'h0);
      check($sformatf("lat7 c%0d ls_done", c), ls_done[2], c == 9);
      check($sformatf("lat7 c%0d busy", c), busy[2], c <= 9);
      if (c >= 9) check($sformatf("lat7 c%0d ls_rdata", c), ls_rdata[2], 32'hA0000008);
      check($sformatf("lat2 c%0d ls_done", c), ls_done[0], c == 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
